ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It consumes rs/rt operands already forwarded by ID, computes MULT/MULTU/DIV/DIVU over multiple cycles, and raises `stallreq` so the pipeline holds EX (and upstream) until the result is ready. The final HI/LO pair is delivered with a one-cycle `ready` pulse, then written back through the existing hi/lo path.

---
 rtl/ex_muldiv_pkg.sv | 37 +++
 rtl/ex_muldiv_if.sv | 27 ++
 rtl/ex_muldiv.sv | 173 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and helpers for the EX-stage iterative multiply/divide unit.
package ex_muldiv_pkg;

    // Iterations per operation; one operand bit is consumed per RUN cycle.
    localparam int MD_ITER = 32;

    // Operation select as decoded by ID; bit 1 = divide, bit 0 = unsigned.
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    // True for DIV/DIVU.
    function automatic logic is_div_op(md_op_e op);
        return op[1];
    endfunction

    // True for MULT/DIV, the two's-complement variants.
    function automatic logic is_signed_op(md_op_e op);
        return ~op[0];
    endfunction

    // Magnitude of a value when it is to be treated as negative, else raw.
    function automatic logic [31:0] mag32(logic [31:0] v, logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_if;
    import ex_muldiv_pkg::*;

    logic        start;     // EX holds a mul/div instruction (level)
    md_op_e      op;        // operation select
    logic [31:0] src_a;     // rs: dividend / multiplicand
    logic [31:0] src_b;     // rt: divisor / multiplier
    logic        annul;     // flush the in-flight operation
    logic        busy;      // unit not idle
    logic        stallreq;  // hold EX and upstream
    logic        ready;     // one-cycle pulse, hi/lo valid
    logic [31:0] hi;        // product high word / remainder
    logic [31:0] lo;        // product low word / quotient

    // EX side: issues operations, consumes results.
    modport master (
        output start, op, src_a, src_b, annul,
        input  busy, stallreq, ready, hi, lo
    );

    // Unit side.
    modport slave (
        input  start, op, src_a, src_b, annul,
        output busy, stallreq, ready, hi, lo
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one operand bit per cycle on
// magnitudes, sign correction folded into the final RUN cycle.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int ITER = MD_ITER
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  md
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    md_state_e        state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    md_op_e           op_q,      op_d;
    logic             neg_res_q, neg_res_d;  // product / quotient negated
    logic             neg_rem_q, neg_rem_d;  // remainder negated (sign of a)
    logic [31:0]      opnd_q,    opnd_d;     // multiplicand or divisor magnitude
    logic [63:0]      acc_q,     acc_d;      // {partial high, shifting low word}
    logic [31:0]      hi_q,      hi_d;
    logic [31:0]      lo_q,      lo_d;

    // Iteration step and sign-correction terms.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] step_acc;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Operand capture terms used when an operation is accepted in IDLE.
    logic        sgn_a;
    logic        sgn_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        accept;

    // One datapath step. Multiply: the low word holds the multiplier and
    // shifts right LSB first while the partial product grows from the top.
    // Divide: the low word holds the dividend and shifts left MSB first;
    // quotient bits enter at the bottom, partial remainder lives on top.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = div_shift - {1'b0, opnd_q};
        step_acc  = {mul_sum, acc_q[31:1]};
        if (is_div_op(op_q)) begin
            if (div_diff[32]) begin
                step_acc = {div_shift[31:0], acc_q[30:0], 1'b0};
            end else begin
                step_acc = {div_diff[31:0], acc_q[30:0], 1'b1};
            end
        end
        // Magnitude results of the last step re-signed for hi/lo. The
        // most-negative quotient wraps back to itself, which is intended.
        prod_fix = neg_res_q ? (64'd0 - step_acc)        : step_acc;
        quo_fix  = neg_res_q ? (32'd0 - step_acc[31:0])  : step_acc[31:0];
        rem_fix  = neg_rem_q ? (32'd0 - step_acc[63:32]) : step_acc[63:32];
    end

    // Operand magnitudes and sign flags; unsigned ops never negate.
    always_comb begin
        sgn_a  = is_signed_op(md.op) & md.src_a[31];
        sgn_b  = is_signed_op(md.op) & md.src_b[31];
        mag_a  = mag32(md.src_a, sgn_a);
        mag_b  = mag32(md.src_b, sgn_b);
        accept = md.start & ~md.annul;
    end

    // Next-state and next-datapath logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = md.op;
                    neg_res_d = sgn_a ^ sgn_b;
                    neg_rem_d = sgn_a;
                    cnt_d     = '0;
                    if (is_div_op(md.op)) begin
                        opnd_d = mag_b;
                        acc_d  = {32'd0, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {32'd0, mag_b};
                    end
                    // Divide by zero skips the iteration with a fixed answer.
                    if (is_div_op(md.op) && (md.src_b == 32'd0)) begin
                        hi_d    = md.src_a;
                        lo_d    = 32'hFFFF_FFFF;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    if (is_div_op(op_q)) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush abandons the operation and leaves the last result intact.
        if (md.annul) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // Controller and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= MD_MULT;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Stall is dropped in DONE so EX advances in the same cycle ready pulses.
    assign md.busy     = (state_q != ST_IDLE);
    assign md.ready    = (state_q == ST_DONE) & ~md.annul;
    assign md.stallreq = md.start & (state_q != ST_DONE) & ~md.annul;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: cycle-accurate ready/stallreq timing and
// hand-computed HI/LO results.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    ex_muldiv_if mdi ();

    ex_muldiv #(.ITER(MD_ITER)) dut (
        .clk (clk),
        .rst (rst),
        .md  (mdi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (start of the next cycle).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue an op in the current cycle (cycle 0), hold start until ready,
    // then drop start in the following cycle.
    task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int          cyc;
        int          rdy_cyc;
        int          stall_bad;
        logic        stall_at_rdy;
        logic [31:0] hi_v;
        logic [31:0] lo_v;
        mdi.start = 1'b1;
        mdi.op    = op;
        mdi.src_a = a;
        mdi.src_b = b;
        #1;
        chk({tag, " stallreq c0"}, 64'(mdi.stallreq), 64'd1);
        cyc          = 0;
        rdy_cyc      = -1;
        stall_bad    = 0;
        stall_at_rdy = 1'bx;
        hi_v         = 'x;
        lo_v         = 'x;
        while (rdy_cyc < 0 && cyc < 100) begin
            next_cycle();
            cyc++;
            if (mdi.ready === 1'b1) begin
                rdy_cyc      = cyc;
                stall_at_rdy = mdi.stallreq;
                hi_v         = mdi.hi;
                lo_v         = mdi.lo;
            end else if (mdi.stallreq !== 1'b1) begin
                stall_bad++;
            end
        end
        $display("op=%s a=%h b=%h ready_cycle=%0d hi=%h lo=%h", op.name(), a, b, rdy_cyc, hi_v, lo_v);
        chk({tag, " ready cycle"}, 64'(rdy_cyc), 64'(exp_cyc));
        chk({tag, " hi"}, 64'(hi_v), 64'(exp_hi));
        chk({tag, " lo"}, 64'(lo_v), 64'(exp_lo));
        chk({tag, " stallreq at ready"}, 64'(stall_at_rdy), 64'd0);
        chk({tag, " stallreq gaps"}, 64'(stall_bad), 64'd0);
        next_cycle();
        mdi.start = 1'b0;
        #1;
        chk({tag, " busy after"}, 64'(mdi.busy), 64'd0);
    endtask

    initial begin
        int rdy_seen;
        int cyc;
        int first_rdy;
        int second_rdy;
        logic [31:0] r1_hi, r1_lo, r2_hi, r2_lo;

        rst       = 1'b1;
        mdi.start = 1'b0;
        mdi.op    = MD_MULT;
        mdi.src_a = '0;
        mdi.src_b = '0;
        mdi.annul = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        chk("reset busy", 64'(mdi.busy), 64'd0);
        chk("reset ready", 64'(mdi.ready), 64'd0);
        chk("reset stallreq", 64'(mdi.stallreq), 64'd0);
        chk("reset hi", 64'(mdi.hi), 64'd0);
        chk("reset lo", 64'(mdi.lo), 64'd0);

        // Annul has priority over start: no stall request, nothing launched.
        mdi.start = 1'b1;
        mdi.annul = 1'b1;
        #1;
        chk("annul beats start stallreq", 64'(mdi.stallreq), 64'd0);
        next_cycle();
        mdi.start = 1'b0;
        mdi.annul = 1'b0;
        #1;
        chk("annul beats start busy", 64'(mdi.busy), 64'd0);

        next_cycle();
        run_op("divu 100/7", MD_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        next_cycle();
        run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        next_cycle();
        run_op("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
        next_cycle();
        run_op("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
        next_cycle();
        run_op("mult -3*5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        next_cycle();
        run_op("mult -1*-1", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0, 32'h1);
        next_cycle();
        run_op("multu max*max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);
        next_cycle();
        run_op("div 5/0", MD_DIV, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF);

        // DIVU flushed in cycle 10; prior result (5/0) must survive.
        next_cycle();
        mdi.start = 1'b1;
        mdi.op    = MD_DIVU;
        mdi.src_a = 32'd1000;
        mdi.src_b = 32'd3;
        rdy_seen  = 0;
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            if (mdi.ready !== 1'b0) rdy_seen++;
        end
        mdi.annul = 1'b1;
        #1;
        chk("annul c10 stallreq", 64'(mdi.stallreq), 64'd0);
        chk("annul c10 ready", 64'(mdi.ready), 64'd0);
        next_cycle();
        mdi.annul = 1'b0;
        mdi.start = 1'b0;
        #1;
        $display("op=DIVU a=000003e8 b=00000003 annulled cycle=10 hi=%h lo=%h", mdi.hi, mdi.lo);
        chk("annul c11 busy", 64'(mdi.busy), 64'd0);
        chk("annul no ready", 64'(rdy_seen + int'(mdi.ready)), 64'd0);
        chk("annul hi kept", 64'(mdi.hi), 64'd5);
        chk("annul lo kept", 64'(mdi.lo), 64'hFFFF_FFFF);
        next_cycle();
        run_op("multu 6*7 after annul", MD_MULTU, 32'd6, 32'd7, 33, 32'd0, 32'd42);

        // Synchronous reset in cycle 20 of a MULT.
        next_cycle();
        mdi.start = 1'b1;
        mdi.op    = MD_MULT;
        mdi.src_a = 32'd123;
        mdi.src_b = 32'd456;
        for (int c = 1; c <= 20; c++) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst       = 1'b0;
        mdi.start = 1'b0;
        #1;
        $display("op=MULT a=0000007b b=000001c8 reset cycle=20 hi=%h lo=%h", mdi.hi, mdi.lo);
        chk("rst mid busy", 64'(mdi.busy), 64'd0);
        chk("rst mid ready", 64'(mdi.ready), 64'd0);
        chk("rst mid stallreq", 64'(mdi.stallreq), 64'd0);
        chk("rst mid hi", 64'(mdi.hi), 64'd0);
        chk("rst mid lo", 64'(mdi.lo), 64'd0);

        // Back-to-back DIVU 50/5 then MULT -2*3 with start held throughout.
        next_cycle();
        mdi.start  = 1'b1;
        mdi.op     = MD_DIVU;
        mdi.src_a  = 32'd50;
        mdi.src_b  = 32'd5;
        cyc        = 0;
        first_rdy  = -1;
        second_rdy = -1;
        r1_hi = 'x; r1_lo = 'x; r2_hi = 'x; r2_lo = 'x;
        while (second_rdy < 0 && cyc < 150) begin
            next_cycle();
            cyc++;
            if (first_rdy >= 0 && cyc == first_rdy + 1) begin
                mdi.op    = MD_MULT;
                mdi.src_a = 32'hFFFF_FFFE;
                mdi.src_b = 32'd3;
            end
            if (mdi.ready === 1'b1) begin
                if (first_rdy < 0) begin
                    first_rdy = cyc;
                    r1_hi = mdi.hi;
                    r1_lo = mdi.lo;
                end else begin
                    second_rdy = cyc;
                    r2_hi = mdi.hi;
                    r2_lo = mdi.lo;
                end
            end
        end
        mdi.start = 1'b0;
        $display("op=DIVU a=00000032 b=00000005 ready_cycle=%0d hi=%h lo=%h", first_rdy, r1_hi, r1_lo);
        $display("op=MULT a=fffffffe b=00000003 ready_cycle=%0d hi=%h lo=%h", second_rdy, r2_hi, r2_lo);
        chk("b2b first ready cycle", 64'(first_rdy), 64'd33);
        chk("b2b first hi", 64'(r1_hi), 64'd0);
        chk("b2b first lo", 64'(r1_lo), 64'd10);
        chk("b2b second ready cycle", 64'(second_rdy), 64'd67);
        chk("b2b second hi", 64'(r2_hi), 64'hFFFF_FFFF);
        chk("b2b second lo", 64'(r2_lo), 64'hFFFF_FFFA);

        next_cycle();
        next_cycle();
        chk("final idle busy", 64'(mdi.busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
